// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared constants, types and helpers for the register-file
// write-back path and its outstanding-write scoreboard.
package regfile_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam int                  SB_CNT_W   = 2;
    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = 2'd3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Next value of one scoreboard counter. A simultaneous issue and commit
    // cancel out. Both directions saturate, so a commit with nothing
    // outstanding leaves the counter at zero.
    function automatic logic [SB_CNT_W-1:0] sb_cnt_next(
        input logic [SB_CNT_W-1:0] cnt,
        input logic                inc,
        input logic                dec
    );
        logic [SB_CNT_W-1:0] res;
        case ({inc, dec})
            2'b10:   res = (cnt == SB_CNT_MAX)        ? cnt : cnt + SB_CNT_W'(1);
            2'b01:   res = (cnt == {SB_CNT_W{1'b0}}) ? cnt : cnt - SB_CNT_W'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_chk.sv
// regfile_wb_arbiter_chk: simulation-only protocol checks for the write-back
// controller (grant sanity and write-backs without a matching issue).
module regfile_wb_arbiter_chk #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 5,
    parameter int SB_CNT_W = 2
) (
    input logic                clk,
    input logic                rst,
    input logic [NUM_REQ-1:0]  req_valid,
    input logic [NUM_REQ-1:0]  gnt,
    input logic                rd_we,
    input logic [ADDR_W-1:0]   rd_addr,
    input logic [SB_CNT_W-1:0] commit_cnt
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt))
        else $error("write-back grant is not one-hot: %b", gnt);

    a_gnt_subset: assert property (@(posedge clk) disable iff (rst)
        ((gnt & ~req_valid) == {NUM_REQ{1'b0}}))
        else $error("grant %b to a requester that is not valid (%b)", gnt, req_valid);

    a_gnt_when_req: assert property (@(posedge clk) disable iff (rst)
        (|req_valid) |-> (|gnt))
        else $error("valid requests %b but no grant", req_valid);

    a_wb_has_issue: assert property (@(posedge clk) disable iff (rst)
        (rd_we && (rd_addr != {ADDR_W{1'b0}})) |-> (commit_cnt != {SB_CNT_W{1'b0}}))
        else $error("write-back to x%0d with no outstanding issue", rd_addr);

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: one-hot grant generator for the write-back port.
// With WB_ARB_RR_EN defined it is round-robin: the search starts at a pointer
// that moves to one past the last grantee. Otherwise it is fixed priority
// (index 0 highest) and holds no state.
module wb_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    logic found_s;

`ifdef WB_ARB_RR_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] gnt_idx_s;
    logic [PTR_W-1:0] idx_s;
    logic             hit_s;

    // Walk the requests starting at the pointer; the first one found wins.
    always_comb begin
        gnt       = {NUM_REQ{1'b0}};
        found_s   = 1'b0;
        gnt_idx_s = {PTR_W{1'b0}};
        idx_s     = {PTR_W{1'b0}};
        hit_s     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s      = PTR_W'((int'(ptr_r) + k) % NUM_REQ);
            hit_s      = req[idx_s] & ~found_s;
            gnt[idx_s] = hit_s;
            gnt_idx_s  = hit_s ? idx_s : gnt_idx_s;
            found_s    = found_s | req[idx_s];
        end
    end

    // Move the pointer past the grantee; hold it when nobody was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (found_s) begin
            ptr_r <= (gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}}
                                                         : gnt_idx_s + PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority has no state, so clock and reset are not needed.
    logic unused_s;
    assign unused_s = clk ^ rst;

    // Lowest-indexed valid request wins.
    always_comb begin
        gnt     = {NUM_REQ{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt[k]  = req[k] & ~found_s;
            found_s = found_s | req[k];
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port among
// NUM_REQ execution units through one output register stage, and keeps a
// per-register count of outstanding writes for decode hazard checks.
// Optional feature: define WB_ARB_RR_EN for round-robin arbitration
// (fixed priority, index 0 highest, otherwise).
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
    input  logic [NUM_REQ*XLEN-1:0]   req_rd_data,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [XLEN-1:0]           rd_data,
    output logic                      rd_we,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_rd_addr,
    output logic                      issue_ready,
    input  logic [ADDR_W-1:0]         rs1_query,
    input  logic [ADDR_W-1:0]         rs2_query,
    output logic                      rs1_busy,
    output logic                      rs2_busy
);

    import regfile_ctrl_pkg::*;

    localparam int NREG = 1 << ADDR_W;

    logic [NUM_REQ-1:0]       gnt_s;
    logic                     xfer_s;
    logic [ADDR_W-1:0]        win_addr_s;
    logic [XLEN-1:0]          win_data_s;

    logic [ADDR_W-1:0]        rd_addr_r;
    logic [XLEN-1:0]          rd_data_r;
    logic                     rd_we_r;

    logic                     issue_fire_s;
    logic [NREG*SB_CNT_W-1:0] cnt_flat_s;
    logic [SB_CNT_W-1:0]      issue_cnt_s;
    logic [SB_CNT_W-1:0]      rs1_cnt_s;
    logic [SB_CNT_W-1:0]      rs2_cnt_s;
    logic [SB_CNT_W-1:0]      commit_cnt_s;

    wb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt_s)
    );

    assign req_ready = gnt_s;
    assign xfer_s    = |gnt_s;

    // One-hot AND-OR mux of the granted requester's destination and data.
    always_comb begin
        win_addr_s = {ADDR_W{1'b0}};
        win_data_s = {XLEN{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            win_addr_s = win_addr_s | (req_rd_addr[k*ADDR_W +: ADDR_W] & {ADDR_W{gnt_s[k]}});
            win_data_s = win_data_s | (req_rd_data[k*XLEN +: XLEN] & {XLEN{gnt_s[k]}});
        end
    end

    // Output stage: latch the winner; x0 writes are consumed without a write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_r <= {ADDR_W{1'b0}};
            rd_data_r <= {XLEN{1'b0}};
            rd_we_r   <= 1'b0;
        end else if (xfer_s) begin
            rd_addr_r <= win_addr_s;
            rd_data_r <= win_data_s;
            rd_we_r   <= (win_addr_s != {ADDR_W{1'b0}});
        end else begin
            rd_addr_r <= rd_addr_r;
            rd_data_r <= rd_data_r;
            rd_we_r   <= 1'b0;
        end
    end

    assign rd_addr = rd_addr_r;
    assign rd_data = rd_data_r;
    assign rd_we   = rd_we_r;

    // Slot 0 of the flat counter view is a constant zero: x0 is never
    // outstanding, so it never blocks an issue and never reads as busy.
    assign cnt_flat_s[SB_CNT_W-1:0] = {SB_CNT_W{1'b0}};

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        logic [SB_CNT_W-1:0] cnt_r;
        logic                inc_s;
        logic                dec_s;

        assign inc_s = issue_fire_s && (issue_rd_addr == ADDR_W'(r));
        assign dec_s = rd_we_r && (rd_addr_r == ADDR_W'(r));
        assign cnt_flat_s[r*SB_CNT_W +: SB_CNT_W] = cnt_r;

        // Outstanding-write counter for register r: +1 on issue, -1 on commit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r <= {SB_CNT_W{1'b0}};
            end else begin
                cnt_r <= sb_cnt_next(cnt_r, inc_s, dec_s);
            end
        end
    end

    assign issue_cnt_s  = cnt_flat_s[issue_rd_addr*SB_CNT_W +: SB_CNT_W];
    assign rs1_cnt_s    = cnt_flat_s[rs1_query*SB_CNT_W +: SB_CNT_W];
    assign rs2_cnt_s    = cnt_flat_s[rs2_query*SB_CNT_W +: SB_CNT_W];
    assign commit_cnt_s = cnt_flat_s[rd_addr_r*SB_CNT_W +: SB_CNT_W];

    assign issue_ready  = (issue_cnt_s != SB_CNT_MAX);
    assign issue_fire_s = issue_valid && issue_ready && (issue_rd_addr != {ADDR_W{1'b0}});
    assign rs1_busy     = (rs1_cnt_s != {SB_CNT_W{1'b0}});
    assign rs2_busy     = (rs2_cnt_s != {SB_CNT_W{1'b0}});

    regfile_wb_arbiter_chk #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .SB_CNT_W (SB_CNT_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .gnt        (gnt_s),
        .rd_we      (rd_we_r),
        .rd_addr    (rd_addr_r),
        .commit_cnt (commit_cnt_s)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter.
// Expected grant order follows WB_ARB_RR_EN.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int ADDR_W  = 5;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_rd_addr = '0;
    logic [NUM_REQ*XLEN-1:0]   req_rd_data = '0;
    logic [ADDR_W-1:0]         rd_addr;
    logic [XLEN-1:0]           rd_data;
    logic                      rd_we;
    logic                      issue_valid = 1'b0;
    logic [ADDR_W-1:0]         issue_rd_addr = '0;
    logic                      issue_ready;
    logic [ADDR_W-1:0]         rs1_query = '0;
    logic [ADDR_W-1:0]         rs2_query = '0;
    logic                      rs1_busy;
    logic                      rs2_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [NUM_REQ-1:0] exp_g;
    logic [XLEN-1:0]    exp_d;

    regfile_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .XLEN    (XLEN),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd_addr   (req_rd_addr),
        .req_rd_data   (req_rd_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_we         (rd_we),
        .issue_valid   (issue_valid),
        .issue_rd_addr (issue_rd_addr),
        .issue_ready   (issue_ready),
        .rs1_query     (rs1_query),
        .rs2_query     (rs2_query),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        req_rd_addr[i*ADDR_W +: ADDR_W] = a;
        req_rd_data[i*XLEN +: XLEN]     = d;
    endtask

    initial begin
        // ---- reset state ----
        issue_rd_addr = 5'd5;
        rs1_query     = 5'd5;
        rs2_query     = 5'd7;
        #1;
        chk("rst_rd_we",       64'(rd_we),       64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_rs1_busy",    64'(rs1_busy),    64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("idle_rd_we",       64'(rd_we),       64'd0);
        chk("idle_rd_addr",     64'(rd_addr),     64'd0);
        chk("idle_rd_data",     64'(rd_data),     64'd0);
        chk("idle_issue_ready", 64'(issue_ready), 64'd1);
        chk("idle_rs1_busy",    64'(rs1_busy),    64'd0);
        chk("idle_rs2_busy",    64'(rs2_busy),    64'd0);

        // ---- arbitration: all three valid, writing x0 with distinct data ----
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'd0, 32'h0000_00A0 + 32'(i));
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
`ifdef WB_ARB_RR_EN
            exp_g = 3'b001 << (c % 3);
            exp_d = 32'h0000_00A0 + 32'(c % 3);
`else
            exp_g = 3'b001;
            exp_d = 32'h0000_00A0;
`endif
            #1;
            chk("arb_grant", 64'(req_ready), 64'(exp_g));
            tick();
            chk("arb_rd_data", 64'(rd_data), 64'(exp_d));
            chk("arb_x0_we",   64'(rd_we),   64'd0);
        end
        req_valid = 3'b110;
        #1;
        chk("arb_grant_110", 64'(req_ready), 64'(3'b010));
        tick();
        chk("arb_data_110", 64'(rd_data), 64'h0000_00A1);
        req_valid = 3'b011;
        #1;
        chk("arb_grant_011", 64'(req_ready), 64'(3'b001));
        tick();
        chk("arb_data_011", 64'(rd_data), 64'h0000_00A0);
        req_valid = 3'b000;
        #1;
        chk("arb_no_grant", 64'(req_ready), 64'd0);
        tick();
        chk("arb_idle_we", 64'(rd_we), 64'd0);

        // ---- issue x5, then req0 writes x5 = DEADBEEF ----
        issue_valid   = 1'b1;
        issue_rd_addr = 5'd5;
        rs1_query     = 5'd5;
        #1;
        chk("x5_issue_ready", 64'(issue_ready), 64'd1);
        chk("x5_busy_before", 64'(rs1_busy),    64'd0);
        tick();
        issue_valid = 1'b0;
        chk("x5_busy_after_issue", 64'(rs1_busy), 64'd1);
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b001;
        #1;
        chk("x5_req_ready", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = 3'b000;
        chk("x5_rd_we",     64'(rd_we),    64'd1);
        chk("x5_rd_addr",   64'(rd_addr),  64'd5);
        chk("x5_rd_data",   64'(rd_data),  64'hDEAD_BEEF);
        chk("x5_busy_n1",   64'(rs1_busy), 64'd1);
        tick();
        chk("x5_rd_we_off", 64'(rd_we),    64'd0);
        chk("x5_busy_n2",   64'(rs1_busy), 64'd0);

        // ---- x7: fill to 3, commit alongside a blocked issue, then drain ----
        issue_valid   = 1'b1;
        issue_rd_addr = 5'd7;
        rs2_query     = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("x7_fill_ready", 64'(issue_ready), 64'd1);
            tick();
        end
        issue_valid = 1'b0;
        #1;
        chk("x7_full_ready", 64'(issue_ready), 64'd0);
        chk("x7_busy",       64'(rs2_busy),    64'd1);
        set_req(0, 5'd7, 32'h0000_0077);
        req_valid = 3'b001;
        tick();
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        #1;
        chk("x7_commit_we",    64'(rd_we),       64'd1);
        chk("x7_commit_ready", 64'(issue_ready), 64'd0);
        tick();
        tick();
        issue_valid = 1'b0;
        #1;
        chk("x7_refull_ready", 64'(issue_ready), 64'd0);
        req_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 5'd7, 32'h0000_0070 + 32'(i));
            tick();
            chk("x7_b2b_we",   64'(rd_we),   64'd1);
            chk("x7_b2b_data", 64'(rd_data), 64'h0000_0070 + 64'(i));
        end
        req_valid = 3'b000;
        chk("x7_busy_last", 64'(rs2_busy), 64'd1);
        tick();
        chk("x7_drained_we",    64'(rd_we),       64'd0);
        chk("x7_drained_busy",  64'(rs2_busy),    64'd0);
        chk("x7_drained_ready", 64'(issue_ready), 64'd1);

        // ---- req1 writes x0 ----
        set_req(1, 5'd0, 32'h0000_1234);
        req_valid     = 3'b010;
        issue_rd_addr = 5'd0;
        rs1_query     = 5'd0;
        #1;
        chk("x0_req_ready",   64'(req_ready),   64'(3'b010));
        chk("x0_issue_ready", 64'(issue_ready), 64'd1);
        chk("x0_rs1_busy",    64'(rs1_busy),    64'd0);
        tick();
        req_valid = 3'b000;
        chk("x0_rd_we",   64'(rd_we),   64'd0);
        chk("x0_rd_addr", 64'(rd_addr), 64'd0);
        chk("x0_rd_data", 64'(rd_data), 64'h0000_1234);

        // ---- issue x3 while x3 commits ----
        issue_valid   = 1'b1;
        issue_rd_addr = 5'd3;
        rs2_query     = 5'd3;
        tick();
        issue_valid = 1'b0;
        set_req(0, 5'd3, 32'h0000_0033);
        req_valid = 3'b001;
        tick();
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        #1;
        chk("x3_commit_we",    64'(rd_we),       64'd1);
        chk("x3_issue_ready",  64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0;
        chk("x3_busy_held", 64'(rs2_busy), 64'd1);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        chk("x3_busy_commit2", 64'(rs2_busy), 64'd1);
        tick();
        chk("x3_busy_clear", 64'(rs2_busy), 64'd0);

        // ---- reset asserted mid-write ----
        issue_valid   = 1'b1;
        issue_rd_addr = 5'd9;
        rs1_query     = 5'd9;
        tick();
        issue_valid = 1'b0;
        set_req(0, 5'd9, 32'h0000_0099);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        chk("mid_rd_we",   64'(rd_we),    64'd1);
        chk("mid_busy",    64'(rs1_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we",    64'(rd_we),       64'd0);
        chk("mid_rst_addr",  64'(rd_addr),     64'd0);
        chk("mid_rst_data",  64'(rd_data),     64'd0);
        chk("mid_rst_busy",  64'(rs1_busy),    64'd0);
        chk("mid_rst_ready", 64'(issue_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_we",   64'(rd_we),    64'd0);
        chk("post_rst_busy", 64'(rs1_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
